uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Sits directly downstream of the UART frame receiver on the same clk_16bd domain.
- Consumes received bytes and assembles 5-byte command packets: SYNC, ADDR, DATA_HI, DATA_LO, CHK.
- Verifies the XOR checksum and issues a held register-write request (addr + 16-bit data) toward the VGA control registers, with ack handshake.
- Reports errors (checksum, inter-byte timeout, overrun) as pulse + code plus a saturating error count.

Parameters:
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT, 64, max idle cycles allowed between bytes inside a packet (must be ≥2).
- TO_W, 7, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk_16bd  in  1  clock; the one clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame  in  9  received frame; bits [7:0] used, bit 8 ignored.
- frame_valid  in  1  one-cycle strobe; frame is valid in that cycle.
- wr_req  out  1  write request; held high until acknowledged.
- wr_addr  out  8  register address; stable while wr_req=1.
- wr_data  out  16  register data {DATA_HI, DATA_LO}; stable while wr_req=1.
- wr_ack  in  1  consumer accepts the write when wr_req=1 and wr_ack=1 at a clock edge.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  cause of the last error: 01 checksum, 10 timeout, 11 overrun; holds until the next error.
- err_count  out  8  total errors, saturates at 255.
- busy  out  1  high in any state other than HUNT.

Behaviour:
- Reset (async, any time, including mid-packet or mid-write):
  - state=HUNT; wr_req=0; wr_addr=0; wr_data=0; err_pulse=0; err_code=0; err_count=0; timeout counter=0.
  - A partial packet is discarded.
- All outputs are registered. A byte is accepted only on an edge where frame_valid=1.
- States: HUNT, ADDR, DHI, DLO, CHK, WRITE.
  - HUNT: byte==SYNC_BYTE → ADDR. Any other byte is ignored silently (no error).
  - ADDR: latch byte into addr shadow → DHI.
  - DHI: latch byte into data[15:8] → DLO.
  - DLO: latch byte into data[7:0] → CHK.
  - CHK: if byte == addr^data[15:8]^data[7:0], load wr_addr/wr_data, set wr_req=1 the next cycle, and go to WRITE. Otherwise err code 01 → HUNT.
  - WRITE: wr_req held. On an edge with wr_ack=1, wr_req=0 the next cycle → HUNT.
  - Latency from the CHK-byte strobe edge to wr_req high: 1 cycle.
- SYNC_BYTE appearing inside a packet (ADDR..CHK) is treated as ordinary data; there is no resync.
- Timeout (states ADDR, DHI, DLO, CHK only):
  - The counter clears on entry to these states and on every accepted byte, and increments on every other cycle.
  - When it reaches TIMEOUT with no byte: err code 10 → HUNT, counter cleared.
  - If frame_valid arrives on the same edge the counter would reach TIMEOUT, the byte wins and no timeout occurs.
  - The counter is frozen at 0 in HUNT and WRITE.
- Overrun: frame_valid=1 in WRITE drops the byte, raises err code 11, and stays in WRITE.
  - If wr_ack and frame_valid occur on the same edge, the write completes (→ HUNT) and the byte is still dropped with an overrun error.
- Error reporting:
  - Each error gives err_pulse=1 for exactly one cycle, the cycle after the detecting edge.
  - err_code updates in that same cycle.
  - err_count increments in that same cycle, saturating at 8'hFF.
  - At most one error is reported per edge.
- wr_ack while wr_req=0 is ignored.
- wr_addr and wr_data change only when entering WRITE.
- busy = (state != HUNT), registered together with the state.

Test Plan:
- Bytes A5 10 12 34 36, one strobe every 16 cycles → wr_req rises 1 cycle after the 36 strobe, wr_addr=8'h10, wr_data=16'h1234. Hold wr_ack=0 for 5 cycles: wr_req and data stay stable. Pulse wr_ack: wr_req falls next cycle, busy=0.
- Bytes A5 10 12 34 37 → no wr_req; err_pulse for 1 cycle, err_code=01, err_count=1, state back to HUNT.
- TIMEOUT=16: bytes A5 10 then silence → err_code=10 on the 16th idle cycle after the 10 strobe. A byte landing exactly on that edge → no error and the packet continues.
- Bytes 00 FF 5A then A5 01 00 02 03 → leading bytes ignored with no error; write addr 01, data 0002.
- During WRITE (wr_ack=0) send byte 55 → err_code=11, err_count increments, wr_req stays 1 with the data unchanged.
- Assert rst after A5 10 12 → all outputs 0 immediately (async). Then send 34 36 → no write; a fresh A5 20 00 01 21 → write addr 20, data 0001.
- Force 256 checksum errors → err_count=255 and holds.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles SYNC/ADDR/DHI/DLO/CHK byte packets into held register writes with error reporting
module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT = 64,
  parameter int TO_W = 7
) (
  input  logic        clk_16bd,
  input  logic        rst,
  input  logic [8:0]  frame,
  input  logic        frame_valid,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_ack,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count,
  output logic        busy
);
  typedef enum logic [2:0] {HUNT, ADDR, DHI, DLO, CHK, WRITE} state_t;
  state_t state_q;
  logic [7:0] rx, addr_q, dhi_q, dlo_q, wr_addr_q, err_count_q;
  logic [15:0] wr_data_q;
  logic [TO_W-1:0] to_q;
  logic [1:0] err_code_q, code_d;
  logic wr_req_q, busy_q, err_pulse_q, in_pkt, to_hit, chk_ok, err_d;
  logic unused_frame_bit;
  assign rx = frame[7:0];
  assign unused_frame_bit = frame[8];
  assign in_pkt = state_q inside {ADDR, DHI, DLO, CHK};
  assign to_hit = to_q == TO_W'(TIMEOUT - 1);
  assign chk_ok = rx == (addr_q ^ dhi_q ^ dlo_q);
  // A byte on the same edge as the timeout wins, so timeout only fires on idle edges
  assign err_d = frame_valid ? (state_q == WRITE || (state_q == CHK && !chk_ok)) : (in_pkt && to_hit);
  assign code_d = state_q == WRITE ? 2'b11 : frame_valid ? 2'b01 : 2'b10;
  assign wr_req = wr_req_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign err_pulse = err_pulse_q;
  assign err_code = err_code_q;
  assign err_count = err_count_q;
  assign busy = busy_q;
  // Packet FSM: busy and wr_req are registered alongside each state transition
  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      busy_q <= 1'b0;
      wr_req_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      addr_q <= '0;
      dhi_q <= '0;
      dlo_q <= '0;
      to_q <= '0;
    end else begin
      case (state_q)
        HUNT: if (frame_valid && rx == SYNC_BYTE) begin
          state_q <= ADDR;
          busy_q <= 1'b1;
        end
        WRITE: if (wr_ack) begin
          state_q <= HUNT;
          busy_q <= 1'b0;
          wr_req_q <= 1'b0;
        end
        default: if (frame_valid) begin
          to_q <= '0;
          case (state_q)
            ADDR: begin
              addr_q <= rx;
              state_q <= DHI;
            end
            DHI: begin
              dhi_q <= rx;
              state_q <= DLO;
            end
            DLO: begin
              dlo_q <= rx;
              state_q <= CHK;
            end
            default: if (chk_ok) begin
              wr_addr_q <= addr_q;
              wr_data_q <= {dhi_q, dlo_q};
              wr_req_q <= 1'b1;
              state_q <= WRITE;
            end else begin
              state_q <= HUNT;
              busy_q <= 1'b0;
            end
          endcase
        end else if (to_hit) begin
          to_q <= '0;
          state_q <= HUNT;
          busy_q <= 1'b0;
        end else begin
          to_q <= to_q + 1'b1;
        end
      endcase
    end
  end
  // Error strobe, sticky cause and saturating count
  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      err_pulse_q <= 1'b0;
      err_code_q <= '0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= err_d;
      if (err_d) begin
        err_code_q <= code_d;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed scoreboard bench for uart_cmd_decoder with TIMEOUT=16
module tb_uart_cmd_decoder;
  logic clk = 1'b0, rst = 1'b1, frame_valid = 1'b0, wr_ack = 1'b0;
  logic [8:0] frame = '0;
  logic wr_req, err_pulse, busy;
  logic [7:0] wr_addr, err_count;
  logic [15:0] wr_data;
  logic [1:0] err_code;
  int n_assert = 0, n_fail = 0;
  logic [23:0] exp_wr[$];
  logic [1:0] exp_err[$];
  logic [23:0] e_wr;
  logic [1:0] e_err;
  logic wr_req_prev = 1'b0;

  uart_cmd_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT(16), .TO_W(5)) dut (
    .clk_16bd(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; strobes one byte on the following posedge and returns at the next negedge
  task automatic send(input logic [7:0] b);
    frame = {1'b0, b};
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
    send(8'hA5);
    send(a);
    send(h);
    send(l);
    send(c);
  endtask

  task automatic ack();
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: compare each new write and each error strobe against queued expectations
  always @(negedge clk) begin
    if (wr_req && !wr_req_prev) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 32'(1), 32'(0));
      else begin
        e_wr = exp_wr.pop_front();
        check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(e_wr));
      end
    end
    if (err_pulse) begin
      if (exp_err.size() == 0) check("err_unexpected", 32'(err_code), 32'(0));
      else begin
        e_err = exp_err.pop_front();
        check("err_code_sb", 32'(err_code), 32'(e_err));
      end
    end
    wr_req_prev <= wr_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check("rst_outputs", 32'({wr_req, wr_addr, wr_data, err_pulse, err_code, err_count, busy}), 32'(0));
    rst = 1'b0;
    idle(2);
    // Good packet, strobes 16 cycles apart
    exp_wr.push_back({8'h10, 16'h1234});
    send(8'hA5);
    idle(15); send(8'h10);
    idle(15); send(8'h12);
    idle(15); send(8'h34);
    idle(15); send(8'h36);
    check("wr_req_latency", 32'(wr_req), 32'(1));
    check("busy_write", 32'(busy), 32'(1));
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("wr_hold", 32'({wr_req, wr_addr, wr_data}), 32'({1'b1, 8'h10, 16'h1234}));
    end
    ack();
    check("wr_req_fall", 32'({wr_req, busy}), 32'(0));
    check("no_err_good", 32'(err_count), 32'(0));
    // Checksum error
    exp_err.push_back(2'b01);
    pkt(8'h10, 8'h12, 8'h34, 8'h37);
    check("chk_err", 32'({err_pulse, err_code, err_count}), 32'({1'b1, 2'b01, 8'd1}));
    check("chk_err_idle", 32'({wr_req, busy}), 32'(0));
    idle(1);
    check("chk_pulse_once", 32'(err_pulse), 32'(0));
    // Timeout after 16 idle edges
    exp_err.push_back(2'b10);
    send(8'hA5);
    send(8'h10);
    idle(15);
    check("to_not_yet", 32'({err_pulse, busy}), 32'({1'b0, 1'b1}));
    idle(1);
    check("to_err", 32'({err_pulse, err_code, err_count, busy}), 32'({1'b1, 2'b10, 8'd2, 1'b0}));
    // Byte landing on the would-be timeout edge wins
    exp_wr.push_back({8'h10, 16'h1234});
    send(8'hA5);
    send(8'h10);
    idle(15);
    send(8'h12);
    check("to_byte_wins", 32'({err_pulse, busy, err_count}), 32'({1'b0, 1'b1, 8'd2}));
    send(8'h34);
    send(8'h36);
    check("to_pkt_write", 32'(wr_req), 32'(1));
    ack();
    // Leading garbage ignored
    exp_wr.push_back({8'h01, 16'h0002});
    send(8'h00); send(8'hFF); send(8'h5A);
    check("garbage_quiet", 32'({busy, err_count}), 32'({1'b0, 8'd2}));
    pkt(8'h01, 8'h00, 8'h02, 8'h03);
    check("garbage_write", 32'({wr_req, wr_addr, wr_data}), 32'({1'b1, 8'h01, 16'h0002}));
    // Overrun during WRITE
    exp_err.push_back(2'b11);
    send(8'h55);
    check("ovr_err", 32'({err_pulse, err_code, err_count}), 32'({1'b1, 2'b11, 8'd3}));
    check("ovr_hold", 32'({wr_req, busy, wr_addr, wr_data}), 32'({2'b11, 8'h01, 16'h0002}));
    // Ack and byte on the same edge
    exp_err.push_back(2'b11);
    wr_ack = 1'b1;
    send(8'h55);
    wr_ack = 1'b0;
    check("ack_ovr", 32'({wr_req, busy, err_pulse, err_code, err_count}), 32'({3'b001, 2'b11, 8'd4}));
    // Ack in HUNT ignored
    ack();
    check("ack_idle", 32'({wr_req, busy}), 32'(0));
    // Async reset mid-packet
    send(8'hA5); send(8'h10); send(8'h12);
    #2 rst = 1'b1;
    #1 check("async_rst", 32'({wr_req, wr_addr, wr_data, err_pulse, err_code, err_count, busy}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    send(8'h34); send(8'h36);
    check("partial_dropped", 32'({wr_req, busy, err_count}), 32'(0));
    exp_wr.push_back({8'h20, 16'h0001});
    pkt(8'h20, 8'h00, 8'h01, 8'h21);
    check("post_rst_write", 32'({wr_req, wr_addr, wr_data}), 32'({1'b1, 8'h20, 16'h0001}));
    ack();
    // Error count saturation
    for (int i = 0; i < 256; i++) begin
      exp_err.push_back(2'b01);
      pkt(8'h00, 8'h00, 8'h00, 8'h01);
    end
    check("sat_255", 32'(err_count), 32'(255));
    exp_err.push_back(2'b01);
    pkt(8'h00, 8'h00, 8'h00, 8'h01);
    check("sat_hold", 32'({err_pulse, err_count}), 32'({1'b1, 8'd255}));
    idle(2);
    check("sb_wr_empty", 32'(exp_wr.size()), 32'(0));
    check("sb_err_empty", 32'(exp_err.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
